pll_reset_sequencer: RTL and testbench

//  - Consumes the PLL's clock_out (as clock_in here) and its asynchronous locked flag.
//  - Releases a clean, glitch-free fabric reset only after the PLL has been locked

---
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies the PLL lock flag and generates a clean,
// registered active-low fabric reset. Lock must be seen continuously for
// STABLE_CYCLES, followed by HOLD_CYCLES of margin, before release. Any loss of
// lock drops the reset again.
// Optional feature macro: LOCK_LOSS_COUNT_EN (saturating RUN lock-loss counter).
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_W        = 8
) (
  input  logic              clock_in,
  input  logic              resetb,
  input  logic              locked,
  output logic              sys_resetn,
  output logic              ready,
  output logic [1:0]        state_dbg,
  output logic [LOSS_W-1:0] lock_loss_count
);

  localparam int MAX_CYC = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_resetn_q, sys_resetn_d;
  logic                   ready_q, ready_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous lock flag; only lock_s is used downstream.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  // Sequencer state, qualification counter and registered reset outputs.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      sys_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_resetn_q <= sys_resetn_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic: any lock_s drop restarts qualification from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered from the next state so they move on the same
    // edge as the state register.
    sys_resetn_d = (state_d == RUN);
    ready_d      = (state_d == RUN);
  end

  assign sys_resetn = sys_resetn_q;
  assign ready      = ready_q;
  assign state_dbg  = state_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic              run_exit;
  logic [LOSS_W-1:0] loss_q, loss_d;

  assign run_exit = (state_q == RUN) && !lock_s;

  // Saturating count of RUN -> WAIT_LOCK transitions.
  always_comb begin
    loss_d = loss_q;
    if (run_exit && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_W'(1);
    end
  end

  // Lock-loss counter register, cleared only by resetb.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with
// SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, LOSS_W=2.
module tb_pll_reset_sequencer;

  logic       clock_in;
  logic       resetb;
  logic       locked;
  logic       sys_resetn;
  logic       ready;
  logic [1:0] state_dbg;
  logic [1:0] lock_loss_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .HOLD_CYCLES  (4),
    .LOSS_W       (2)
  ) dut (
    .clock_in       (clock_in),
    .resetb         (resetb),
    .locked         (locked),
    .sys_resetn     (sys_resetn),
    .ready          (ready),
    .state_dbg      (state_dbg),
    .lock_loss_count(lock_loss_count)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock_in);
    #2;
  endtask

  // Expected lock-loss count after the n-th loss (LOSS_W=2 saturates at 3).
  function automatic logic [31:0] exp_loss(input int unsigned n);
`ifdef LOCK_LOSS_COUNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'(n & 0);
`endif
  endfunction

  // From WAIT_LOCK with lock_s low: raise locked, expect release after edge 15.
  task automatic lock_to_run(input string tag);
    locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 3)  chk({tag, "_st_stable"}, 32'(state_dbg), 32'd1);
      if (k == 11) chk({tag, "_st_hold"},   32'(state_dbg), 32'd2);
      if (k == 14) chk({tag, "_rst_e14"},   32'(sys_resetn), 32'd0);
    end
    chk({tag, "_rst_e15"},   32'(sys_resetn), 32'd1);
    chk({tag, "_ready_e15"}, 32'(ready), 32'd1);
    chk({tag, "_st_run"},    32'(state_dbg), 32'd3);
  endtask

  // From RUN: drop locked, expect reset low exactly after the 3rd edge.
  task automatic lose_lock(input string tag, input int unsigned nth);
    locked = 1'b0;
    step();
    step();
    chk({tag, "_rst_e2"}, 32'(sys_resetn), 32'd1);
    step();
    chk({tag, "_rst_e3"},   32'(sys_resetn), 32'd0);
    chk({tag, "_ready_e3"}, 32'(ready), 32'd0);
    chk({tag, "_st_e3"},    32'(state_dbg), 32'd0);
    chk({tag, "_count"},    32'(lock_loss_count), exp_loss(nth));
  endtask

  initial begin
    int unsigned err_before;
    resetb = 1'b0;
    locked = 1'b1;

    // 1: asynchronous reset values, before any clock edge.
    #1;
    chk("reset_rstn",  32'(sys_resetn), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_count", 32'(lock_loss_count), 32'd0);
    step();
    step();
    chk("reset_hold_state", 32'(state_dbg), 32'd0);

    // 2: clean lock, locked high from edge 1.
    resetb = 1'b1;
    lock_to_run("clean");

    // 4: loss in RUN.
    lose_lock("loss1", 1);

    // 5: further losses, saturating count.
    for (int unsigned n = 2; n <= 5; n++) begin
      lock_to_run("relock");
      lose_lock("lossn", n);
    end

    // 3: glitch in STABLE restarts qualification.
    @(posedge clock_in);
    #2;
    resetb = 1'b0;
    #1;
    chk("glitch_pre_count", 32'(lock_loss_count), 32'd0);
    step();
    resetb = 1'b1;
    locked = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    locked = 1'b0;                 // sampled low at edge 7
    step();
    locked = 1'b1;                 // sampled high again at edge 8
    step();
    step();                        // edge 9
    chk("glitch_state0", 32'(state_dbg), 32'd0);
    for (int k = 3; k <= 14; k++) step();
    chk("glitch_rst_e14", 32'(sys_resetn), 32'd0);
    step();
    chk("glitch_rst_e15", 32'(sys_resetn), 32'd1);
    chk("glitch_st_run",  32'(state_dbg), 32'd3);

    // 6: async reset mid-HOLD, then fresh qualification.
    lose_lock("loss_g", 1);
    locked = 1'b1;
    for (int k = 1; k <= 12; k++) step();
    chk("midhold_state", 32'(state_dbg), 32'd2);
    resetb = 1'b0;
    #1;
    chk("midhold_rstn",  32'(sys_resetn), 32'd0);
    chk("midhold_ready", 32'(ready), 32'd0);
    chk("midhold_state0", 32'(state_dbg), 32'd0);
    chk("midhold_count", 32'(lock_loss_count), 32'd0);
    step();
    resetb = 1'b1;
    err_before = n_errors;
    lock_to_run("after_rst");
    if (n_errors != err_before) $display("FAIL after_rst: requalification errors %0d required 0", n_errors - err_before);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
